// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if: CPU-side (fetch, load/store) and RAM-side bundle of the
// memory port arbiter.  Revision: 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic              d_err;
  logic [31:0]       d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_dout,
    output if_ack, if_rdata, d_ack, d_err, d_rdata, mem_addr, mem_we, mem_din, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_dout,
    input  if_ack, if_rdata, d_ack, d_err, d_rdata, mem_addr, mem_we, mem_din, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one single-port RAM between fetch and load/store,
// sequencing read latency and doing sub-word stores as read-modify-write.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_rd   = 2'd1;
  localparam logic [1:0] c_st_wr   = 2'd2;
  localparam logic [1:0] c_st_ack  = 2'd3;
  localparam logic [1:0] c_rd_lat  = 2'(RD_LAT);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [1:0]        r_cnt;
  logic              r_last_data;
  logic              r_gnt_data;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [31:0]       r_mem_din;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;

  logic              w_any_req;
  logic              w_sel_data;
  logic              w_misalign;
  logic              w_word_store;
  logic              w_cap;
  logic [31:0]       w_merged;
  logic              w_if_ack;
  logic              w_d_ack;
  logic              w_d_err;
  logic              w_busy;
  logic              w_unused_bits;

  assign w_unused_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                           bus.d_addr[31:ADDR_W+2]};

  // On a tie the requester that was not granted last wins.
  assign w_any_req    = bus.if_req | bus.d_req;
  assign w_sel_data   = bus.d_req & (~bus.if_req | ~r_last_data);
  assign w_misalign   = ((bus.d_size == 2'b01) & bus.d_addr[0]) |
                        (bus.d_size[1] & (bus.d_addr[1:0] != 2'b00));
  assign w_word_store = bus.d_we & bus.d_size[1];
  assign w_cap        = (r_state == c_st_rd) && (r_cnt == c_rd_lat);

  always_comb begin
    w_merged = bus.mem_dout;
    if (bus.d_size == 2'b00)
      w_merged[{bus.d_addr[1:0], 3'b000} +: 8] = bus.d_wdata[7:0];
    else if (bus.d_size == 2'b01)
      w_merged[{bus.d_addr[1], 4'b0000} +: 16] = bus.d_wdata[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_any_req) begin
          if (!w_sel_data)       w_next = c_st_rd;
          else if (w_misalign)   w_next = c_st_ack;
          else if (w_word_store) w_next = c_st_wr;
          else                   w_next = c_st_rd;
        end
      end
      c_st_rd: begin
        if (r_cnt == c_rd_lat)
          w_next = (r_gnt_data && bus.d_we) ? c_st_wr : c_st_ack;
      end
      c_st_wr:  w_next = c_st_ack;
      c_st_ack: w_next = c_st_idle;
      default:  w_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_if_ack = 1'b0;
    w_d_ack  = 1'b0;
    w_d_err  = 1'b0;
    w_busy   = (r_state != c_st_idle);
    if (r_state == c_st_ack) begin
      w_if_ack = ~r_gnt_data;
      w_d_ack  = r_gnt_data;
      w_d_err  = r_gnt_data & r_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 2'd0;
      r_last_data <= 1'b1;
      r_gnt_data  <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_din   <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
    end else begin
      r_mem_we <= (w_next == c_st_wr);
      if (w_next == c_st_rd)
        r_cnt <= (r_state == c_st_rd) ? r_cnt + 2'd1 : 2'd1;
      else
        r_cnt <= 2'd0;

      if (r_state == c_st_idle && w_any_req) begin
        r_gnt_data <= w_sel_data;
        r_err      <= w_sel_data & w_misalign;
        if (!(w_sel_data && w_misalign))
          r_mem_addr <= w_sel_data ? bus.d_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
        if (w_sel_data && w_next == c_st_wr)
          r_mem_din <= bus.d_wdata;
      end

      // mem_din doubles as the merge register for sub-word stores.
      if (w_cap) begin
        if (r_gnt_data) begin
          r_d_rdata <= bus.mem_dout;
          if (bus.d_we) r_mem_din <= w_merged;
        end else begin
          r_if_rdata <= bus.mem_dout;
        end
      end

      if (r_state == c_st_ack) r_last_data <= r_gnt_data;
    end
  end

  assign bus.if_ack   = w_if_ack;
  assign bus.if_rdata = r_if_rdata;
  assign bus.d_ack    = w_d_ack;
  assign bus.d_err    = w_d_err;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_din  = r_mem_din;
  assign bus.busy     = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// tb_mem_port_arbiter: directed vectors with a behavioural RAM of read latency 2.
module tb_mem_port_arbiter;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  mem_port_arbiter_if #(.ADDR_W(10)) bus ();

  mem_port_arbiter #(.ADDR_W(10), .RD_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address registered at the clock edge, data out one cycle later.
  logic [31:0] ram [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we)            ram[bd_addr]      <= bd_data;
    else if (bus.mem_we)  ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Runs one access starting in an idle cycle (cycle 0) and records what was seen.
  task automatic access(input bit fetch, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int ack_cyc, output int we_cyc,
                        output logic [31:0] din_we, output logic [9:0] addr_we,
                        output logic err, output logic [31:0] rdata,
                        output logic [7:0] busy_mask, output bit wrong_ack);
    ack_cyc = -1; we_cyc = -1; din_we = '0; addr_we = '0; err = 1'b0;
    rdata = '0; busy_mask = '0; wrong_ack = 1'b0;
    @(posedge clk); #1;
    if (fetch) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size;
      bus.d_addr = addr; bus.d_wdata = wdata;
    end
    busy_mask[0] = bus.busy;
    for (int c = 1; c < 8 && ack_cyc < 0; c++) begin
      @(posedge clk); #1;
      busy_mask[c] = bus.busy;
      if (bus.mem_we && we_cyc < 0) begin
        we_cyc = c; din_we = bus.mem_din; addr_we = bus.mem_addr;
      end
      if (fetch ? bus.d_ack : bus.if_ack) wrong_ack = 1'b1;
      if (fetch ? bus.if_ack : bus.d_ack) begin
        ack_cyc = c; err = bus.d_err;
        rdata = fetch ? bus.if_rdata : bus.d_rdata;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.if_ack !== 1'b0) begin n_miss++; $display("FAIL reset_if_ack: got %b want 0", bus.if_ack); end
    n_vec++; if (bus.d_ack !== 1'b0) begin n_miss++; $display("FAIL reset_d_ack: got %b want 0", bus.d_ack); end
    n_vec++; if (bus.d_err !== 1'b0) begin n_miss++; $display("FAIL reset_d_err: got %b want 0", bus.d_err); end
    n_vec++; if (bus.if_rdata !== 32'h0) begin n_miss++; $display("FAIL reset_if_rdata: got %h want 0", bus.if_rdata); end
    n_vec++; if (bus.d_rdata !== 32'h0) begin n_miss++; $display("FAIL reset_d_rdata: got %h want 0", bus.d_rdata); end
    n_vec++; if (bus.mem_addr !== 10'h0) begin n_miss++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    n_vec++; if (bus.mem_we !== 1'b0) begin n_miss++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    n_vec++; if (bus.mem_din !== 32'h0) begin n_miss++; $display("FAIL reset_mem_din: got %h want 0", bus.mem_din); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    int ack_cyc, we_cyc; logic [31:0] din, rd; logic [9:0] wa; logic err; logic [7:0] bm; bit wa_k;
    poke(10'd5, 32'h11223344);
    access(1'b1, 1'b0, 2'b10, 32'h14, 32'h0, ack_cyc, we_cyc, din, wa, err, rd, bm, wa_k);
    n_vec++; if (ack_cyc !== 3) begin n_miss++; $display("FAIL fetch_ack_cycle: got %0d want 3", ack_cyc); end
    n_vec++; if (rd !== 32'h11223344) begin n_miss++; $display("FAIL fetch_rdata: got %h want 11223344", rd); end
    n_vec++; if (we_cyc !== -1) begin n_miss++; $display("FAIL fetch_mem_we: got cycle %0d want never", we_cyc); end
    n_vec++; if (bm !== 8'b0000_1110) begin n_miss++; $display("FAIL fetch_busy_mask: got %b want 00001110", bm); end
    n_vec++; if (wa_k !== 1'b0) begin n_miss++; $display("FAIL fetch_wrong_ack: got %b want 0", wa_k); end
  endtask

  task automatic test_subword_store();
    int ack_cyc, we_cyc; logic [31:0] din, rd; logic [9:0] wa; logic err; logic [7:0] bm; bit wa_k;
    poke(10'd2, 32'hAABBCCDD);
    access(1'b0, 1'b1, 2'b00, 32'h09, 32'h000000EE, ack_cyc, we_cyc, din, wa, err, rd, bm, wa_k);
    n_vec++; if (we_cyc !== 3) begin n_miss++; $display("FAIL sb_we_cycle: got %0d want 3", we_cyc); end
    n_vec++; if (din !== 32'hAABBEEDD) begin n_miss++; $display("FAIL sb_mem_din: got %h want aabbeedd", din); end
    n_vec++; if (wa !== 10'd2) begin n_miss++; $display("FAIL sb_mem_addr: got %h want 2", wa); end
    n_vec++; if (ack_cyc !== 4) begin n_miss++; $display("FAIL sb_ack_cycle: got %0d want 4", ack_cyc); end
    n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL sb_err: got %b want 0", err); end
    n_vec++; if (rd !== 32'hAABBCCDD) begin n_miss++; $display("FAIL sb_rdata: got %h want aabbccdd", rd); end
    n_vec++; if (ram[2] !== 32'hAABBEEDD) begin n_miss++; $display("FAIL sb_ram: got %h want aabbeedd", ram[2]); end
    access(1'b0, 1'b1, 2'b01, 32'h0A, 32'h00001234, ack_cyc, we_cyc, din, wa, err, rd, bm, wa_k);
    n_vec++; if (we_cyc !== 3) begin n_miss++; $display("FAIL sh_we_cycle: got %0d want 3", we_cyc); end
    n_vec++; if (din !== 32'h1234EEDD) begin n_miss++; $display("FAIL sh_mem_din: got %h want 1234eedd", din); end
    n_vec++; if (ack_cyc !== 4) begin n_miss++; $display("FAIL sh_ack_cycle: got %0d want 4", ack_cyc); end
    n_vec++; if (rd !== 32'hAABBEEDD) begin n_miss++; $display("FAIL sh_rdata: got %h want aabbeedd", rd); end
    n_vec++; if (ram[2] !== 32'h1234EEDD) begin n_miss++; $display("FAIL sh_ram: got %h want 1234eedd", ram[2]); end
  endtask

  task automatic test_word_store();
    int ack_cyc, we_cyc; logic [31:0] din, rd; logic [9:0] wa; logic err; logic [7:0] bm; bit wa_k;
    access(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, ack_cyc, we_cyc, din, wa, err, rd, bm, wa_k);
    n_vec++; if (we_cyc !== 1) begin n_miss++; $display("FAIL sw_we_cycle: got %0d want 1", we_cyc); end
    n_vec++; if (wa !== 10'd4) begin n_miss++; $display("FAIL sw_mem_addr: got %h want 4", wa); end
    n_vec++; if (din !== 32'hDEADBEEF) begin n_miss++; $display("FAIL sw_mem_din: got %h want deadbeef", din); end
    n_vec++; if (ack_cyc !== 2) begin n_miss++; $display("FAIL sw_ack_cycle: got %0d want 2", ack_cyc); end
    access(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, ack_cyc, we_cyc, din, wa, err, rd, bm, wa_k);
    n_vec++; if (ack_cyc !== 3) begin n_miss++; $display("FAIL ld_ack_cycle: got %0d want 3", ack_cyc); end
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_miss++; $display("FAIL ld_rdata: got %h want deadbeef", rd); end
    n_vec++; if (we_cyc !== -1) begin n_miss++; $display("FAIL ld_mem_we: got cycle %0d want never", we_cyc); end
  endtask

  task automatic test_misaligned();
    int ack_cyc, we_cyc; logic [31:0] din, rd; logic [9:0] wa; logic err; logic [7:0] bm; bit wa_k;
    poke(10'd0, 32'hCAFEF00D);
    poke(10'd1, 32'h0BADBEEF);
    access(1'b0, 1'b1, 2'b01, 32'h03, 32'h00005555, ack_cyc, we_cyc, din, wa, err, rd, bm, wa_k);
    n_vec++; if (ack_cyc !== 1) begin n_miss++; $display("FAIL mh_ack_cycle: got %0d want 1", ack_cyc); end
    n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL mh_err: got %b want 1", err); end
    n_vec++; if (we_cyc !== -1) begin n_miss++; $display("FAIL mh_mem_we: got cycle %0d want never", we_cyc); end
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_miss++; $display("FAIL mh_rdata_held: got %h want deadbeef", rd); end
    access(1'b0, 1'b1, 2'b10, 32'h06, 32'h12345678, ack_cyc, we_cyc, din, wa, err, rd, bm, wa_k);
    n_vec++; if (ack_cyc !== 1) begin n_miss++; $display("FAIL mw_ack_cycle: got %0d want 1", ack_cyc); end
    n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL mw_err: got %b want 1", err); end
    n_vec++; if (we_cyc !== -1) begin n_miss++; $display("FAIL mw_mem_we: got cycle %0d want never", we_cyc); end
    n_vec++; if (ram[0] !== 32'hCAFEF00D) begin n_miss++; $display("FAIL m_ram0: got %h want cafef00d", ram[0]); end
    n_vec++; if (ram[1] !== 32'h0BADBEEF) begin n_miss++; $display("FAIL m_ram1: got %h want 0badbeef", ram[1]); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] got;
    logic [4:0] exp_seq;
    int  nack;
    bit  dbl, f_pend, d_pend;
    exp_seq = 5'b01010;
    got = '0; nack = 0; dbl = 1'b0; f_pend = 1'b0; d_pend = 1'b0;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h14;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h10;
    for (int c = 0; c < 80 && nack < 5; c++) begin
      @(posedge clk); #1;
      if (f_pend) begin bus.if_req = 1'b1; f_pend = 1'b0; end
      if (d_pend) begin bus.d_req = 1'b1; d_pend = 1'b0; end
      if (bus.if_ack && bus.d_ack) dbl = 1'b1;
      if (bus.if_ack) begin
        got[nack] = 1'b0; nack++; bus.if_req = 1'b0; f_pend = (nack < 4);
      end else if (bus.d_ack) begin
        got[nack] = 1'b1; nack++; bus.d_req = 1'b0; d_pend = (nack < 4);
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    n_vec++; if (nack !== 5) begin n_miss++; $display("FAIL b2b_ack_count: got %0d want 5", nack); end
    n_vec++; if (dbl !== 1'b0) begin n_miss++; $display("FAIL b2b_double_grant: got %b want 0", dbl); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (got[i] !== exp_seq[i]) begin
        n_miss++; $display("FAIL b2b_grant%0d: got %s want %s", i, got[i] ? "data" : "fetch", exp_seq[i] ? "data" : "fetch");
      end
    end
    n_vec++; if (bus.d_rdata !== 32'hDEADBEEF) begin n_miss++; $display("FAIL b2b_d_rdata: got %h want deadbeef", bus.d_rdata); end
  endtask

  task automatic test_reset_midop();
    bit found, stray, f_done, d_done;
    logic [1:0] first;
    int f_cyc;
    logic [31:0] f_data, d_data;
    found = 1'b0; stray = 1'b0; f_done = 1'b0; d_done = 1'b0;
    first = 2'b00; f_cyc = -1; f_data = '0; d_data = '0;
    poke(10'd2, 32'h55667788);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b00; bus.d_addr = 32'h08; bus.d_wdata = 32'h99;
    for (int c = 1; c < 8 && !found; c++) begin
      @(posedge clk); #1;
      if (bus.mem_we) found = 1'b1;
    end
    n_vec++; if (found !== 1'b1) begin n_miss++; $display("FAIL rst_reach_wr: got %b want 1", found); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.mem_we !== 1'b0) begin n_miss++; $display("FAIL rst_mem_we_drop: got %b want 0", bus.mem_we); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.d_ack !== 1'b0) begin n_miss++; $display("FAIL rst_d_ack: got %b want 0", bus.d_ack); end
    n_vec++; if (bus.d_rdata !== 32'h0) begin n_miss++; $display("FAIL rst_d_rdata: got %h want 0", bus.d_rdata); end
    n_vec++; if (bus.if_rdata !== 32'h0) begin n_miss++; $display("FAIL rst_if_rdata: got %h want 0", bus.if_rdata); end
    n_vec++; if (bus.mem_din !== 32'h0) begin n_miss++; $display("FAIL rst_mem_din: got %h want 0", bus.mem_din); end
    n_vec++; if (bus.mem_addr !== 10'h0) begin n_miss++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    bus.d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.if_ack || bus.d_ack) stray = 1'b1;
    end
    n_vec++; if (stray !== 1'b0) begin n_miss++; $display("FAIL rst_stray_ack: got %b want 0", stray); end
    n_vec++; if (ram[2] !== 32'h55667788) begin n_miss++; $display("FAIL rst_ram_untouched: got %h want 55667788", ram[2]); end
    bus.if_req = 1'b1; bus.if_addr = 32'h14;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h08;
    for (int c = 1; c < 16 && !(f_done && d_done); c++) begin
      @(posedge clk); #1;
      if (bus.if_ack) begin
        if (first == 2'b00) first = 2'b01;
        f_cyc = c; f_data = bus.if_rdata; f_done = 1'b1; bus.if_req = 1'b0;
      end
      if (bus.d_ack) begin
        if (first == 2'b00) first = 2'b10;
        d_data = bus.d_rdata; d_done = 1'b1; bus.d_req = 1'b0;
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    n_vec++; if (first !== 2'b01) begin n_miss++; $display("FAIL rst_first_tie: got %b want 01 (fetch)", first); end
    n_vec++; if (f_cyc !== 3) begin n_miss++; $display("FAIL rst_fetch_cycle: got %0d want 3", f_cyc); end
    n_vec++; if (f_data !== 32'h11223344) begin n_miss++; $display("FAIL rst_fetch_data: got %h want 11223344", f_data); end
    n_vec++; if (d_done !== 1'b1) begin n_miss++; $display("FAIL rst_load_done: got %b want 1", d_done); end
    n_vec++; if (d_data !== 32'h55667788) begin n_miss++; $display("FAIL rst_load_data: got %h want 55667788", d_data); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_addr = '0; bus.d_wdata = '0;
    test_reset();
    test_fetch();
    test_subword_store();
    test_word_store();
    test_misaligned();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
